fp_dispatch_queue: RTL and testbench
====================================

FP_DISPATCH_QUEUE -- requirements
Module: fp_dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-002 Parameter TAG_W, default 4: ROB tag width.
REQ-003 clk  input  1: single clock; every state element updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 enq_valid_i  input  1: a decoded FP instruction is offered.
REQ-006 enq_ready_o  output  1: the queue accepts the offered instruction.
REQ-007 enq_op_i  input  5: FP operation number from the FP decoder; 31 = not an FP op.
REQ-008 enq_rm_i  input  3: instruction rm field; enq_fmt_i  input  2: format; enq_tag_i  input  TAG_W: ROB tag.
REQ-009 frm_i  input  3: current frm CSR value.
REQ-010 flush_i  input  1: pipeline flush.
REQ-011 falu_valid_o / falu_ready_i, fdiv_valid_o / fdiv_ready_i, fls_valid_o / fls_ready_i  (out / in, 1 each): per-unit issue handshakes.
REQ-012 iss_op_o 5, iss_rm_o 3, iss_fmt_o 2, iss_tag_o TAG_W (all outputs): payload bus shared by the three issue ports.
REQ-013 fdiv_done_i  input  1: the divide/sqrt unit has completed its outstanding operation.
REQ-014 illegal_valid_o  output  1, illegal_tag_o  output  TAG_W: report of an illegal instruction.
REQ-015 count_o  output  $clog2(DEPTH)+1: current occupancy.

Function
REQ-016 Circular FIFO with read and write pointers one bit wider than the index; full when the indices are equal and the MSBs differ; empty when the pointers are equal.
REQ-017 enq_ready_o = !full; no bypass; an entry written in cycle N is issuable no earlier than cycle N+1.
REQ-018 Issue is in order, from the head only.
REQ-019 Unit class from the head op: FADD..FCVT*, FSGNJ*, FEQ/FLT/FLE, FCLASS, FMV* -> FALU; FDIVS, FSQRTS -> FDIV; FLW, FSW -> FLS.
REQ-020 Effective rm = frm_i when the head rm is 3'b111, otherwise the head rm. iss_rm_o carries the effective rm. The frm_i sample is taken at issue, not at enqueue.
REQ-021 The head is illegal if any of the following holds: op = 31; effective rm is 101, 110 or 111 for an op that uses rounding (arithmetic, FMA, FCVT, FDIV, FSQRT); fmt is 2'b10 or 2'b11.
REQ-022 Illegal head: illegal_valid_o = 1 and illegal_tag_o = the head tag for exactly one cycle, the entry is popped, and no unit valid is raised.
REQ-023 Legal head: exactly one unit valid equals !empty, gated for FDIV by !div_busy. The head pops when the selected valid and ready are both 1.
REQ-024 div_busy is set on an FDIV handshake and cleared by fdiv_done_i. If set and clear occur in the same cycle, set wins.
REQ-025 Payload outputs are driven from the head entry whenever the queue is not empty; they are don't-care when empty.
REQ-026 Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo 2*DEPTH.
REQ-027 flush_i empties the queue next cycle, drops any same-cycle enqueue, forces every valid output (unit valids and illegal_valid_o) to 0 that cycle, and clears div_busy.
REQ-028 Valids, once raised, are not required to hold if flush_i intervenes. Otherwise a valid stays high until its handshake completes.

Reset
REQ-029 With rst high at a clock edge: pointers = 0, count_o = 0, div_busy = 0, every valid output = 0, enq_ready_o = 1 in the following cycle.
REQ-030 Reset asserted mid-operation discards all entries; any in-flight handshake in that cycle is ignored.

Structure
REQ-031 FP operation numbers (FALU_*, FDIVSQRT_*, FLW, FSW, invalid = 31) and the rm encodings (DYN = 3'b111) live in the shared params package.
REQ-032 One sub-module, fp_unit_sel, is combinational. It takes the head op and rm and produces the unit class, the uses-rounding flag and the illegal flag.
REQ-033 Entry storage is a flop array with no reset on the payload fields; only pointers and control state are reset.

Verification
REQ-034 Fill to DEPTH=4 with FADDS and all unit readies 0 -> enq_ready_o=0 and count_o=4; then falu_ready_i=1 -> one pop per cycle, count_o reaches 0 after 4 cycles.
REQ-035 FADDS with rm=111 and frm_i=010 -> iss_rm_o=010 on the FALU port. The same op with frm_i=101 -> illegal_valid_o pulses with that tag and falu_valid_o stays 0.
REQ-036 FDIVS followed by FSQRTS with fdiv_ready_i=1 -> the second op holds fdiv_valid_o=0 until fdiv_done_i, then issues on the next cycle.
REQ-037 Queue holding 3 entries with flush_i and enq_valid_i both high -> next cycle count_o=0, no valid output asserted, and the offered op is not stored.
REQ-038 Full queue with the head handshaking and enq_valid_i high -> enq is rejected (ready=0), count_o drops to 3. The next cycle enq is accepted, and wrap-around ordering of the tags is preserved over 10 random ops.
REQ-039 op=31 at the head -> illegal_valid_o pulses for one cycle and the entry is popped; FLW with fmt=10 -> illegal.

Source files
------------

// File: rtl/fp_dispatch_queue_pkg.sv
// Shared definitions for the FP dispatch queue: FP operation numbers produced
// by the FP decoder, rounding-mode encodings, the issue-unit class and the
// layout of one queue entry's payload (the ROB tag is stored alongside, since
// its width is a module parameter).
package fp_dispatch_queue_pkg;

  // FP operation numbers. Ops 0..10 round; 11..21 are FALU ops that do not.
  localparam logic [4:0] OP_FADDS    = 5'd0;
  localparam logic [4:0] OP_FSUBS    = 5'd1;
  localparam logic [4:0] OP_FMULS    = 5'd2;
  localparam logic [4:0] OP_FMADDS   = 5'd3;
  localparam logic [4:0] OP_FMSUBS   = 5'd4;
  localparam logic [4:0] OP_FNMSUBS  = 5'd5;
  localparam logic [4:0] OP_FNMADDS  = 5'd6;
  localparam logic [4:0] OP_FCVT_W_S  = 5'd7;
  localparam logic [4:0] OP_FCVT_WU_S = 5'd8;
  localparam logic [4:0] OP_FCVT_S_W  = 5'd9;
  localparam logic [4:0] OP_FCVT_S_WU = 5'd10;
  localparam logic [4:0] OP_FSGNJS   = 5'd11;
  localparam logic [4:0] OP_FSGNJNS  = 5'd12;
  localparam logic [4:0] OP_FSGNJXS  = 5'd13;
  localparam logic [4:0] OP_FMINS    = 5'd14;
  localparam logic [4:0] OP_FMAXS    = 5'd15;
  localparam logic [4:0] OP_FEQS     = 5'd16;
  localparam logic [4:0] OP_FLTS     = 5'd17;
  localparam logic [4:0] OP_FLES     = 5'd18;
  localparam logic [4:0] OP_FCLASSS  = 5'd19;
  localparam logic [4:0] OP_FMV_X_W  = 5'd20;
  localparam logic [4:0] OP_FMV_W_X  = 5'd21;
  localparam logic [4:0] OP_FDIVS    = 5'd22;
  localparam logic [4:0] OP_FSQRTS   = 5'd23;
  localparam logic [4:0] OP_FLW      = 5'd24;
  localparam logic [4:0] OP_FSW      = 5'd25;
  localparam logic [4:0] OP_INVALID  = 5'd31;

  // Rounding-mode encodings; 101 and 110 are reserved, 111 defers to frm.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {
    UNIT_FALU = 2'd0,
    UNIT_FDIV = 2'd1,
    UNIT_FLS  = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rm;
    logic [1:0] fmt;
  } fp_entry_t;

  // An effective rm of 111 means frm itself held DYN, which is not a mode.
  function automatic logic rm_is_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

  // Only single (00) and double (01) formats are supported.
  function automatic logic fmt_is_reserved(input logic [1:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/fp_dispatch_queue_unit_sel.sv
// fp_unit_sel: combinational classifier for the queue head.
// Ports:
//   i_op     FP operation number of the head entry
//   i_rm     effective rounding mode (DYN already resolved against frm)
//   o_unit   issue unit class (UNIT_NONE for unknown ops)
//   o_illegal unknown op, or a reserved rm on an op that rounds
module fp_unit_sel
  import fp_dispatch_queue_pkg::*;
(
  input  logic [4:0] i_op,
  input  logic [2:0] i_rm,
  output unit_e      o_unit,
  output logic       o_illegal
);

  logic w_uses_rnd;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_unit     = UNIT_NONE;
    w_uses_rnd = 1'b0;
    case (i_op) inside
      [OP_FADDS:OP_FCVT_S_WU]: begin
        o_unit     = UNIT_FALU;
        w_uses_rnd = 1'b1;
      end
      [OP_FSGNJS:OP_FMV_W_X]: o_unit = UNIT_FALU;
      OP_FDIVS, OP_FSQRTS: begin
        o_unit     = UNIT_FDIV;
        w_uses_rnd = 1'b1;
      end
      OP_FLW, OP_FSW: o_unit = UNIT_FLS;
      default: ;
    endcase
    // Op 31 and the unassigned numbers 26..30 all land in UNIT_NONE.
    o_illegal = (o_unit == UNIT_NONE) || (w_uses_rnd && rm_is_reserved(i_rm));
  end

endmodule

// File: rtl/fp_dispatch_queue.sv
// fp_dispatch_queue: in-order FIFO between the FP decoder and the three FP
// execution units (FALU, FDIV/FSQRT, FP load/store).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enq_*                    decoded instruction in (valid/ready, op, rm, fmt, tag)
//   frm_i                    frm CSR, sampled when the head issues
//   flush_i                  empties the queue and suppresses all valids
//   falu/fdiv/fls_valid_o/_ready_i  per-unit issue handshakes
//   iss_op/rm/fmt/tag_o      head payload shared by all issue ports
//   fdiv_done_i              divide unit finished its outstanding op
//   illegal_valid_o/_tag_o   one-cycle report of an illegal head (popped)
//   count_o                  occupancy
module fp_dispatch_queue
  import fp_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [4:0]               enq_op_i,
  input  logic [2:0]               enq_rm_i,
  input  logic [1:0]               enq_fmt_i,
  input  logic [TAG_W-1:0]         enq_tag_i,
  input  logic [2:0]               frm_i,
  input  logic                     flush_i,
  output logic                     falu_valid_o,
  input  logic                     falu_ready_i,
  output logic                     fdiv_valid_o,
  input  logic                     fdiv_ready_i,
  output logic                     fls_valid_o,
  input  logic                     fls_ready_i,
  output logic [4:0]               iss_op_o,
  output logic [2:0]               iss_rm_o,
  output logic [1:0]               iss_fmt_o,
  output logic [TAG_W-1:0]         iss_tag_o,
  input  logic                     fdiv_done_i,
  output logic                     illegal_valid_o,
  output logic [TAG_W-1:0]         illegal_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_div_busy;
  fp_entry_t        r_mem [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_issue_ok;
  logic             w_illegal;
  logic             w_sel_illegal;
  logic             w_fdiv_hs;
  fp_entry_t        w_head;
  logic [TAG_W-1:0] w_head_tag;
  logic [2:0]       w_eff_rm;
  unit_e            w_unit;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_head_tag = r_tag[r_rptr[AW-1:0]];

  // frm is read at issue time so a CSR write behind a queued op still applies.
  assign w_eff_rm = (w_head.rm == RM_DYN) ? frm_i : w_head.rm;

  fp_unit_sel u_unit_sel (
    .i_op      (w_head.op),
    .i_rm      (w_eff_rm),
    .o_unit    (w_unit),
    .o_illegal (w_sel_illegal)
  );

  assign w_illegal  = w_sel_illegal || fmt_is_reserved(w_head.fmt);
  assign w_issue_ok = !w_empty && !flush_i;

  assign illegal_valid_o = w_issue_ok && w_illegal;
  assign illegal_tag_o   = w_head_tag;
  assign falu_valid_o    = w_issue_ok && !w_illegal && (w_unit == UNIT_FALU);
  assign fdiv_valid_o    = w_issue_ok && !w_illegal && (w_unit == UNIT_FDIV) && !r_div_busy;
  assign fls_valid_o     = w_issue_ok && !w_illegal && (w_unit == UNIT_FLS);

  assign iss_op_o  = w_head.op;
  assign iss_rm_o  = w_eff_rm;
  assign iss_fmt_o = w_head.fmt;
  assign iss_tag_o = w_head_tag;

  assign w_fdiv_hs = fdiv_valid_o && fdiv_ready_i;
  // An illegal head retires on its own; the report is its handshake.
  assign w_pop = illegal_valid_o
              || (falu_valid_o && falu_ready_i)
              || w_fdiv_hs
              || (fls_valid_o && fls_ready_i);

  // No bypass: ready depends only on fullness, even when the head pops.
  assign enq_ready_o = !w_full;
  assign w_push      = enq_valid_i && !w_full && !flush_i;

  assign count_o = r_wptr - r_rptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // NOTE: payload storage is deliberately not reset; the pointers alone decide
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= '{op: enq_op_i, rm: enq_rm_i, fmt: enq_fmt_i};
      r_tag[r_wptr[AW-1:0]] <= enq_tag_i;
    end
  end

  // A new divide handshake outranks a same-cycle completion of the previous one.
  always_ff @(posedge clk) begin
    if (rst || flush_i)   r_div_busy <= 1'b0;
    else if (w_fdiv_hs)   r_div_busy <= 1'b1;
    else if (fdiv_done_i) r_div_busy <= 1'b0;
  end

endmodule

// File: tb/tb_fp_dispatch_queue.sv
module tb_fp_dispatch_queue;
  import fp_dispatch_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq_valid_i;
  logic       enq_ready_o;
  logic [4:0] enq_op_i;
  logic [2:0] enq_rm_i;
  logic [1:0] enq_fmt_i;
  logic [3:0] enq_tag_i;
  logic [2:0] frm_i;
  logic       flush_i;
  logic       falu_valid_o, falu_ready_i;
  logic       fdiv_valid_o, fdiv_ready_i;
  logic       fls_valid_o, fls_ready_i;
  logic [4:0] iss_op_o;
  logic [2:0] iss_rm_o;
  logic [1:0] iss_fmt_o;
  logic [3:0] iss_tag_o;
  logic       fdiv_done_i;
  logic       illegal_valid_o;
  logic [3:0] illegal_tag_o;
  logic [2:0] count_o;

  fp_dispatch_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_op_i(enq_op_i), .enq_rm_i(enq_rm_i), .enq_fmt_i(enq_fmt_i), .enq_tag_i(enq_tag_i),
    .frm_i(frm_i), .flush_i(flush_i),
    .falu_valid_o(falu_valid_o), .falu_ready_i(falu_ready_i),
    .fdiv_valid_o(fdiv_valid_o), .fdiv_ready_i(fdiv_ready_i),
    .fls_valid_o(fls_valid_o), .fls_ready_i(fls_ready_i),
    .iss_op_o(iss_op_o), .iss_rm_o(iss_rm_o), .iss_fmt_o(iss_fmt_o), .iss_tag_o(iss_tag_o),
    .fdiv_done_i(fdiv_done_i),
    .illegal_valid_o(illegal_valid_o), .illegal_tag_o(illegal_tag_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    unit_e      kind;
    logic [3:0] tag;
    logic [2:0] rm;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [4:0] op;
    logic [2:0] rm;
    logic [1:0] fmt;
    unit_e      kind;
    logic [2:0] exp_rm;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one edge; the expected issue is queued only if
  // the queue is accepting it.
  task automatic enq(input logic [4:0] op, input logic [2:0] rm, input logic [1:0] fmt,
                     input logic [3:0] tag, input unit_e kind, input logic [2:0] exp_rm,
                     output bit accepted);
    sb_t e;
    enq_op_i = op; enq_rm_i = rm; enq_fmt_i = fmt; enq_tag_i = tag;
    enq_valid_i = 1'b1;
    #1;
    accepted = enq_ready_o && !flush_i && !rst;
    if (accepted) begin
      e.kind = kind; e.tag = tag; e.rm = exp_rm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    enq_valid_i = 1'b0;
  endtask

  task automatic set_ready(input logic a, input logic d, input logic l);
    falu_ready_i = a; fdiv_ready_i = d; fls_ready_i = l;
  endtask

  task automatic drain(input string name);
    int cyc;
    set_ready(1'b1, 1'b1, 1'b1);
    fdiv_done_i = 1'b1;
    cyc = 0;
    while (count_o != 0 && cyc < 30) begin
      step();
      cyc++;
    end
    check({name, "_count"}, 32'(count_o), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    set_ready(1'b0, 1'b0, 1'b0);
    fdiv_done_i = 1'b0;
  endtask

  // Scoreboard monitor: mid-cycle, any completed issue must match the oldest
  // expected entry.
  always @(negedge clk) begin
    unit_e      got_kind;
    logic [3:0] got_tag;
    bit         fired;
    sb_t        e;
    if (!rst && !flush_i) begin
      fired = 1'b1;
      got_tag = iss_tag_o;
      if (illegal_valid_o) begin
        got_kind = UNIT_NONE;
        got_tag  = illegal_tag_o;
      end else if (falu_valid_o && falu_ready_i) got_kind = UNIT_FALU;
      else if (fdiv_valid_o && fdiv_ready_i)     got_kind = UNIT_FDIV;
      else if (fls_valid_o && fls_ready_i)       got_kind = UNIT_FLS;
      else begin
        fired = 1'b0;
        got_kind = UNIT_NONE;
      end
      if (fired) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected_issue: got kind=%0d tag=%0h, required no issue",
                   got_kind, got_tag);
        end else begin
          e = sb.pop_front();
          check("mon_kind", 32'(got_kind), 32'(e.kind));
          check("mon_tag", 32'(got_tag), 32'(e.tag));
          if (e.kind != UNIT_NONE) check("mon_rm", 32'(iss_rm_o), 32'(e.rm));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    bit   acc;
    int   n;
    int   cyc;
    logic [3:0] tag_ctr;

    // Classification table, run with frm = RDN (010) and all units ready.
    vecs[0]  = '{OP_FADDS,    RM_RNE, 2'b00, UNIT_FALU, RM_RNE};
    vecs[1]  = '{OP_FADDS,    RM_DYN, 2'b00, UNIT_FALU, RM_RDN};
    vecs[2]  = '{OP_FMULS,    3'b101, 2'b00, UNIT_NONE, 3'b000};
    vecs[3]  = '{OP_FMINS,    3'b101, 2'b00, UNIT_FALU, 3'b101};
    vecs[4]  = '{OP_FDIVS,    RM_RTZ, 2'b00, UNIT_FDIV, RM_RTZ};
    vecs[5]  = '{OP_FSQRTS,   3'b110, 2'b00, UNIT_NONE, 3'b000};
    vecs[6]  = '{OP_FLW,      RM_RNE, 2'b00, UNIT_FLS,  RM_RNE};
    vecs[7]  = '{OP_FLW,      RM_RNE, 2'b10, UNIT_NONE, 3'b000};
    vecs[8]  = '{OP_FSW,      RM_DYN, 2'b01, UNIT_FLS,  RM_RDN};
    vecs[9]  = '{OP_INVALID,  RM_RNE, 2'b00, UNIT_NONE, 3'b000};
    vecs[10] = '{OP_FCVT_W_S, RM_DYN, 2'b00, UNIT_FALU, RM_RDN};
    vecs[11] = '{OP_FMV_X_W,  RM_RNE, 2'b11, UNIT_NONE, 3'b000};
    vecs[12] = '{OP_FMADDS,   RM_RMM, 2'b01, UNIT_FALU, RM_RMM};
    vecs[13] = '{OP_FEQS,     3'b110, 2'b00, UNIT_FALU, 3'b110};

    rst = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0;
    enq_op_i = '0; enq_rm_i = '0; enq_fmt_i = '0; enq_tag_i = '0;
    frm_i = RM_RDN; fdiv_done_i = 1'b0;
    set_ready(1'b0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_enq_ready", 32'(enq_ready_o), 32'd1);
    check("rst_falu_valid", 32'(falu_valid_o), 32'd0);
    check("rst_fdiv_valid", 32'(fdiv_valid_o), 32'd0);
    check("rst_fls_valid", 32'(fls_valid_o), 32'd0);
    check("rst_illegal_valid", 32'(illegal_valid_o), 32'd0);

    // Table-driven classification through the scoreboard.
    set_ready(1'b1, 1'b1, 1'b1);
    fdiv_done_i = 1'b1;
    foreach (vecs[i]) begin
      enq(vecs[i].op, vecs[i].rm, vecs[i].fmt, 4'(i), vecs[i].kind, vecs[i].exp_rm, acc);
      check("tbl_accepted", 32'(acc), 32'd1);
      step(); step();
      check("tbl_count", 32'(count_o), 32'd0);
    end
    drain("tbl");

    // Fill with all readies low, then drain one per cycle.
    for (int i = 0; i < 4; i++) enq(OP_FADDS, RM_RNE, 2'b00, 4'(i), UNIT_FALU, RM_RNE, acc);
    check("fill_enq_ready", 32'(enq_ready_o), 32'd0);
    check("fill_count", 32'(count_o), 32'd4);
    check("fill_falu_valid", 32'(falu_valid_o), 32'd1);
    falu_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill_drain_count", 32'(count_o), 32'(4 - k));
    end
    falu_ready_i = 1'b0;

    // DYN with a reserved frm is illegal for a rounding op.
    frm_i = 3'b101;
    enq(OP_FADDS, RM_DYN, 2'b00, 4'd5, UNIT_NONE, 3'b000, acc);
    check("dynbad_illegal_valid", 32'(illegal_valid_o), 32'd1);
    check("dynbad_illegal_tag", 32'(illegal_tag_o), 32'd5);
    check("dynbad_falu_valid", 32'(falu_valid_o), 32'd0);
    step();
    check("dynbad_pulse_len", 32'(illegal_valid_o), 32'd0);
    check("dynbad_count", 32'(count_o), 32'd0);
    frm_i = RM_RDN;

    // Back-to-back divides: the second waits for fdiv_done_i.
    fdiv_ready_i = 1'b1;
    enq(OP_FDIVS, RM_RTZ, 2'b00, 4'd1, UNIT_FDIV, RM_RTZ, acc);
    enq(OP_FSQRTS, RM_RNE, 2'b00, 4'd2, UNIT_FDIV, RM_RNE, acc);
    check("div_busy_valid0", 32'(fdiv_valid_o), 32'd0);
    check("div_busy_count", 32'(count_o), 32'd1);
    step(); step(); step();
    check("div_busy_hold", 32'(fdiv_valid_o), 32'd0);
    fdiv_done_i = 1'b1;
    #1;
    check("div_done_cycle_valid", 32'(fdiv_valid_o), 32'd0);
    step();
    fdiv_done_i = 1'b0;
    #1;
    check("div_second_valid", 32'(fdiv_valid_o), 32'd1);
    check("div_second_tag", 32'(iss_tag_o), 32'd2);
    step();
    check("div_second_count", 32'(count_o), 32'd0);
    fdiv_done_i = 1'b1;
    step();
    fdiv_done_i = 1'b0;
    fdiv_ready_i = 1'b0;

    // Flush with a same-cycle enqueue on a 3-entry queue.
    for (int i = 0; i < 3; i++) enq(OP_FADDS, RM_RNE, 2'b00, 4'(8 + i), UNIT_FALU, RM_RNE, acc);
    enq_op_i = OP_FMULS; enq_rm_i = RM_RNE; enq_fmt_i = 2'b00; enq_tag_i = 4'hA;
    enq_valid_i = 1'b1;
    flush_i = 1'b1;
    falu_ready_i = 1'b1;
    #1;
    check("flush_falu_valid", 32'(falu_valid_o), 32'd0);
    check("flush_illegal_valid", 32'(illegal_valid_o), 32'd0);
    step();
    flush_i = 1'b0;
    enq_valid_i = 1'b0;
    falu_ready_i = 1'b0;
    sb.delete();
    #1;
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_enq_ready", 32'(enq_ready_o), 32'd1);
    check("flush_no_valid", 32'({falu_valid_o, fdiv_valid_o, fls_valid_o, illegal_valid_o}), 32'd0);
    step();
    check("flush_not_stored", 32'(count_o), 32'd0);

    // Full queue with the head popping: enqueue rejected this cycle only.
    for (int i = 0; i < 4; i++) enq(OP_FADDS, RM_RNE, 2'b00, 4'(i), UNIT_FALU, RM_RNE, acc);
    falu_ready_i = 1'b1;
    enq_op_i = OP_FADDS; enq_rm_i = RM_RUP; enq_fmt_i = 2'b00; enq_tag_i = 4'd4;
    enq_valid_i = 1'b1;
    #1;
    check("full_enq_ready", 32'(enq_ready_o), 32'd0);
    step();
    check("full_pop_count", 32'(count_o), 32'd3);
    enq(OP_FADDS, RM_RUP, 2'b00, 4'd4, UNIT_FALU, RM_RUP, acc);
    check("full_retry_accepted", 32'(acc), 32'd1);
    check("full_retry_count", 32'(count_o), 32'd3);

    // Random readies and ops; the scoreboard checks order across wrap.
    n = 0;
    cyc = 0;
    tag_ctr = 4'd5;
    while (n < 10 && cyc < 200) begin
      falu_ready_i = 1'($urandom_range(0, 1));
      fls_ready_i  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        enq_rm_i = 3'($urandom_range(0, 4));
        enq(OP_FADDS, enq_rm_i, 2'b00, tag_ctr, UNIT_FALU, enq_rm_i, acc);
      end else begin
        enq(OP_FSW, RM_RNE, 2'b01, tag_ctr, UNIT_FLS, RM_RNE, acc);
      end
      if (acc) begin
        n++;
        tag_ctr++;
      end
      cyc++;
    end
    check("rand_enq_count", 32'(n), 32'd10);
    drain("rand");

    // Invalid op and reserved fmt at the head.
    enq(OP_INVALID, RM_RNE, 2'b00, 4'd9, UNIT_NONE, 3'b000, acc);
    check("op31_illegal_valid", 32'(illegal_valid_o), 32'd1);
    check("op31_illegal_tag", 32'(illegal_tag_o), 32'd9);
    step();
    check("op31_pulse_len", 32'(illegal_valid_o), 32'd0);
    check("op31_count", 32'(count_o), 32'd0);
    enq(OP_FLW, RM_RNE, 2'b10, 4'd3, UNIT_NONE, 3'b000, acc);
    check("flwfmt_illegal_valid", 32'(illegal_valid_o), 32'd1);
    check("flwfmt_fls_valid", 32'(fls_valid_o), 32'd0);
    step();
    check("flwfmt_count", 32'(count_o), 32'd0);

    // Reset mid-operation with a handshake pending.
    enq(OP_FADDS, RM_RNE, 2'b00, 4'd6, UNIT_FALU, RM_RNE, acc);
    enq(OP_FADDS, RM_RNE, 2'b00, 4'd7, UNIT_FALU, RM_RNE, acc);
    rst = 1'b1;
    falu_ready_i = 1'b1;
    step();
    rst = 1'b0;
    falu_ready_i = 1'b0;
    sb.delete();
    #1;
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_falu_valid", 32'(falu_valid_o), 32'd0);
    check("midrst_enq_ready", 32'(enq_ready_o), 32'd1);

    step();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
